// File: rtl/alu_regfile_unit.sv
// MIPS execution core: 32x32 register file with write-through bypass
// and a combinational 32-bit ALU sharing one package boundary.
module alu_regfile_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  addr_a,
    output logic [31:0] data_a,
    input  logic [4:0]  addr_b,
    output logic [31:0] data_b,
    input  logic        en_w,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [4:0]  debug_addr,
    output logic [31:0] debug_data,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  oper,
    output logic [31:0] result
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11
    } alu_op_e;

    logic [31:0] regs [32];
    logic        wr_hit;
    logic [4:0]  sh;

    assign wr_hit = en_w && (addr_w != 5'd0);
    assign sh     = a[4:0];

    // r0 is never written, so it stays at its reset value of zero
    function automatic logic [31:0] rd_port(input logic [4:0] ad,
                                            input logic [31:0] st);
        logic [31:0] v;
        v = st;
        if (ad == 5'd0)
            v = 32'd0;
        else if (wr_hit && (addr_w == ad))
            v = data_w;
        return v;
    endfunction

    // Register array: async clear, WB write on rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (wr_hit) begin
            regs[addr_w] <= data_w;
        end
    end

    // Read ports with same-cycle write-through so ID sees the WB value
    always_comb begin
        data_a     = rd_port(addr_a, regs[addr_a]);
        data_b     = rd_port(addr_b, regs[addr_b]);
        debug_data = rd_port(debug_addr, regs[debug_addr]);
    end

    // ALU: only a[4:0] feeds the shifter; undefined opcodes yield zero
    always_comb begin
        result = 32'd0;
        unique case (oper)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'd0, a < b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLL:  result = b << sh;
            OP_SRL:  result = b >> sh;
            OP_SRA:  result = $unsigned($signed(b) >>> sh);
            OP_LUI:  result = {b[15:0], 16'd0};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Bench for alu_regfile_unit: directed literal checks plus a random
// run compared every cycle against an array/arithmetic model.
module tb_alu_regfile_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  addr_a;
    logic [31:0] data_a;
    logic [4:0]  addr_b;
    logic [31:0] data_b;
    logic        en_w;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  oper;
    logic [31:0] result;

    int total;
    int bad;
    bit chk_en;

    logic [31:0] mdl [32];

    alu_regfile_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_a     (addr_a),
        .data_a     (data_a),
        .addr_b     (addr_b),
        .data_b     (data_b),
        .en_w       (en_w),
        .addr_w     (addr_w),
        .data_w     (data_w),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .a          (a),
        .b          (b),
        .oper       (oper),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference register contents
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                mdl[i] = 32'd0;
        end else if (en_w && addr_w != 5'd0) begin
            mdl[addr_w] = data_w;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ad);
        if (ad == 5'd0)
            return 32'd0;
        if (en_w && addr_w == ad && addr_w != 5'd0)
            return data_w;
        return mdl[ad];
    endfunction

    function automatic logic [31:0] exp_alu(input logic [3:0] op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        int unsigned n;
        logic [31:0] fill;
        longint unsigned sum;
        n = x % 32;
        case (op)
            4'd0: begin
                sum = longint'(x) + longint'(y);
                return sum[31:0];
            end
            4'd1: begin
                sum = 64'h1_0000_0000 + longint'(x) - longint'(y);
                return sum[31:0];
            end
            4'd2: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000))
                         ? 32'd1 : 32'd0;
            4'd3: return (x < y) ? 32'd1 : 32'd0;
            4'd4: return x & y;
            4'd5: return x | y;
            4'd6: return x ^ y;
            4'd7: return 32'hFFFF_FFFF ^ (x | y);
            4'd8: return y * (32'd1 << n);
            4'd9: return y / (32'd1 << n);
            4'd10: begin
                fill = y[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0;
                return (y / (32'd1 << n)) | fill;
            end
            4'd11: return (y % 32'h1_0000) * 32'h1_0000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_data_a", data_a, exp_rd(addr_a));
            chk("cyc_data_b", data_b, exp_rd(addr_b));
            chk("cyc_debug", debug_data, exp_rd(debug_addr));
            chk("cyc_result", result, exp_alu(oper, a, b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_lit(input string nm, input logic [3:0] op,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp);
        oper = op;
        a    = x;
        b    = y;
        #1;
        chk(nm, result, exp);
        chk({nm, "_mdl"}, exp_alu(op, x, y), exp);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        chk_en     = 1'b0;
        rst_n      = 1'b1;
        addr_a     = 5'd0;
        addr_b     = 5'd0;
        en_w       = 1'b0;
        addr_w     = 5'd0;
        data_w     = 32'd0;
        debug_addr = 5'd0;
        a          = 32'd0;
        b          = 32'd0;
        oper       = 4'd0;
        #1 rst_n = 1'b0;
        step();
        addr_a = 5'd3;
        addr_b = 5'd31;
        #1;
        chk("rst_data_a", data_a, 32'd0);
        chk("rst_data_b", data_b, 32'd0);
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;

        // Write r5 then async reset clears it without a clock edge
        step();
        en_w   = 1'b1;
        addr_w = 5'd5;
        data_w = 32'h0000_1234;
        step();
        en_w   = 1'b0;
        addr_a = 5'd5;
        #1;
        chk("r5_written", data_a, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        chk("r5_async_clr", data_a, 32'd0);
        #1 rst_n = 1'b1;

        // r0 write is discarded
        step();
        en_w   = 1'b1;
        addr_w = 5'd0;
        data_w = 32'hFFFF_FFFF;
        addr_a = 5'd0;
        #1;
        chk("r0_before", data_a, 32'd0);
        step();
        en_w = 1'b0;
        #1;
        chk("r0_after", data_a, 32'd0);

        // Bypass of r7 in the writing cycle, r8 unwritten
        step();
        en_w   = 1'b1;
        addr_w = 5'd7;
        data_w = 32'hDEAD_BEEF;
        addr_a = 5'd7;
        addr_b = 5'd8;
        #1;
        chk("byp_before", data_a, 32'hDEAD_BEEF);
        chk("r8_unwritten", data_b, 32'd0);
        step();
        en_w = 1'b0;
        #1;
        chk("byp_after", data_a, 32'hDEAD_BEEF);

        // Debug port, and en_w=0 leaves registers alone
        step();
        en_w       = 1'b1;
        addr_w     = 5'd31;
        data_w     = 32'h0040_0004;
        debug_addr = 5'd31;
        step();
        en_w   = 1'b0;
        data_w = 32'h5555_AAAA;
        step();
        #1;
        chk("debug_r31", debug_data, 32'h0040_0004);

        // ALU literals
        alu_lit("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_lit("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_lit("slt", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_lit("sltu", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_lit("and", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        alu_lit("or", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        alu_lit("xor", 4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        alu_lit("nor", 4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
        alu_lit("sll", 4'd8, 32'd4, 32'd1, 32'h0000_0010);
        alu_lit("srl", 4'd9, 32'd31, 32'h8000_0000, 32'd1);
        alu_lit("sra", 4'd10, 32'd4, 32'h8000_0000, 32'hF800_0000);
        alu_lit("sll_amt", 4'd8, 32'h24, 32'd1, 32'h0000_0010);
        alu_lit("lui", 4'd11, 32'h0, 32'h0000_1234, 32'h1234_0000);
        alu_lit("undef13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

        // Random traffic, compared every cycle by the negedge process
        for (int i = 0; i < 3000; i++) begin
            step();
            en_w   = ($urandom_range(0, 2) != 0);
            addr_w = 5'($urandom_range(0, 31));
            data_w = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                addr_a     = 5'($urandom_range(0, 7));
                addr_b     = 5'($urandom_range(0, 7));
                debug_addr = 5'($urandom_range(0, 7));
                addr_w     = 5'($urandom_range(0, 7));
            end else begin
                addr_a     = 5'($urandom_range(0, 31));
                addr_b     = 5'($urandom_range(0, 31));
                debug_addr = 5'($urandom_range(0, 31));
            end
            oper = 4'($urandom_range(0, 15));
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 3) == 0)
                a = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0)
                b = 32'hFFFF_FFFF;
        end

        step();
        chk_en = 1'b0;
        en_w   = 1'b0;
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
